// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg : shared types and constants for the two-requester ALU arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SEL_AND  = 4'd0;
  localparam logic [3:0] SEL_OR   = 4'd1;
  localparam logic [3:0] SEL_NOT  = 4'd2;
  localparam logic [3:0] SEL_NOR  = 4'd3;
  localparam logic [3:0] SEL_XOR  = 4'd4;
  localparam logic [3:0] SEL_NAND = 4'd5;

  // Bit positions inside the 4-bit response flag vector
  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2 : combinational two-way round-robin grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = enable && (valid0 || valid1);
  // On a tie the requester that was not served last wins
  assign grant_id    = (valid0 && valid1) ? ~last_grant : valid1;

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter : shares one combinational ALU between two requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done
);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic             op_cin;
  logic             op_id;

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_sel;
  logic             in_cin;
  logic             in_illegal;

  rr_arbiter2 u_rr (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .enable      (state == IDLE),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid &&  grant_id;

  assign in_a       = grant_id ? req1_a   : req0_a;
  assign in_b       = grant_id ? req1_b   : req0_b;
  assign in_sel     = grant_id ? req1_sel : req0_sel;
  assign in_cin     = grant_id ? req1_cin : req0_cin;
  assign in_illegal = (32'(in_sel) >= NUM_OPS);

  // ALU inputs come straight from the operand registers so they stay put
  // through EXEC and are untouched by rejected (illegal) operations.
  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = op_sel;
  assign alu_cin = op_cin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      op_cin     <= 1'b0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_id;
            if (in_illegal) begin
              rsp_err   <= 1'b1;
              rsp_y     <= '0;
              rsp_flags <= '0;
              rsp_id    <= grant_id;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              op_a   <= in_a;
              op_b   <= in_b;
              op_sel <= in_sel;
              op_cin <= in_cin;
              op_id  <= grant_id;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_y                <= alu_y;
          rsp_flags[FLAG_COUT] <= alu_cout;
          rsp_flags[FLAG_NEG]  <= alu_negative;
          rsp_flags[FLAG_ZERO] <= alu_zero;
          rsp_flags[FLAG_OVF]  <= alu_overflow;
          rsp_err              <= 1'b0;
          rsp_id               <= op_id;
          rsp_valid            <= 1'b1;
          state                <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter : scoreboard bench for alu_arbiter with a behavioural ALU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]       req0_sel = '0, req1_sel = '0;
  logic             req0_cin = 1'b0, req1_cin = 1'b0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [3:0]       alu_sel;
  logic             alu_cin, alu_cout, alu_negative, alu_zero, alu_overflow;
  logic             rsp_valid, rsp_id, rsp_err;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_y;
  logic [3:0]       rsp_flags;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .NUM_OPS(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .ops_done(ops_done)
  );

  // Behavioural ALU: returns {cout, neg, zero, ovf, y}
  function automatic logic [WIDTH+3:0] alu_ref(input logic [WIDTH-1:0] a, b,
                                               input logic [3:0] sel, input logic cin);
    logic [WIDTH-1:0] y;
    case (sel)
      SEL_AND:  y = a & b;
      SEL_OR:   y = a | b;
      SEL_NOT:  y = ~a;
      SEL_NOR:  y = ~(a | b);
      SEL_XOR:  y = a ^ b;
      SEL_NAND: y = ~(a & b);
      default:  y = '0;
    endcase
    return {cin, y[WIDTH-1], (y == '0), a[WIDTH-1] ^ b[WIDTH-1], y};
  endfunction

  always_comb begin
    {alu_cout, alu_negative, alu_zero, alu_overflow, alu_y} = alu_ref(alu_a, alu_b, alu_sel, alu_cin);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] y;
    logic [3:0]       fl;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               exp_done = 0;
  logic             last_gnt = 1'b1;
  logic [3:0]       last_legal_sel = '0;
  logic             prev_valid = 1'b0, prev_hs = 1'b0, hold = 1'b0;
  logic [WIDTH+5:0] held_vec = '0;

  always @(negedge clk) begin
    exp_t e;
    logic [WIDTH+3:0] r;
    cyc++;
    if (rst) begin
      sb.delete();
      exp_done   = 0;
      last_gnt   = 1'b1;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      hold       = 1'b0;
      last_legal_sel = '0;
    end else begin
      chk("ready_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
      chk("ops_done", 64'(ops_done), 64'(exp_done % 16));
      if (rsp_valid) chk("ready_in_resp", {63'd0, req0_ready | req1_ready}, 64'd0);
      if (prev_hs) chk("rsp_drop", {63'd0, rsp_valid}, 64'd0);
      if (hold && rsp_valid) chk("rsp_stable", 64'({rsp_id, rsp_err, rsp_flags, rsp_y}), 64'(held_vec));
      if (req0_ready || req1_ready) begin
        e.id = req1_ready;
        if (req0_valid && req1_valid) chk("rr_grant", {63'd0, e.id}, {63'd0, ~last_gnt});
        last_gnt = e.id;
        if (e.id) r = alu_ref(req1_a, req1_b, req1_sel, req1_cin);
        else      r = alu_ref(req0_a, req0_b, req0_sel, req0_cin);
        e.err = ((e.id ? req1_sel : req0_sel) >= 4'd6);
        e.y   = e.err ? '0 : r[WIDTH-1:0];
        e.fl  = e.err ? '0 : r[WIDTH+3:WIDTH];
        e.cyc = cyc;
        if (!e.err) last_legal_sel = e.id ? req1_sel : req0_sel;
        sb.push_back(e);
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else begin
          chk("latency", 64'(cyc - sb[0].cyc), sb[0].err ? 64'd1 : 64'd2);
          if (sb[0].err) chk("alu_sel_kept", 64'(alu_sel), 64'(last_legal_sel));
        end
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
        chk("rsp_y", 64'(rsp_y), 64'(e.y));
        chk("rsp_flags", 64'(rsp_flags), 64'(e.fl));
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        exp_done++;
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      hold       = rsp_valid && !rsp_ready;
      held_vec   = {rsp_id, rsp_err, rsp_flags, rsp_y};
    end
  end

  // Present one operation and hold it until accepted; called at posedge+1
  task automatic send(input logic id, input logic [WIDTH-1:0] a, b,
                      input logic [3:0] sel, input logic cin);
    int n = 0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; req1_cin = cin; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; req0_cin = cin; end
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? req1_ready : req0_ready) && n < 200);
    if (n >= 200) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_rsp_y", 64'(rsp_y), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    @(posedge clk); #1;

    // Single op
    send(1'b0, 32'd1, 32'd1, SEL_AND, 1'b0);
    wait_idle();

    // Contention: 4 ops from each requester, both held valid
    fork
      for (int i = 0; i < 4; i++) send(1'b0, $urandom, $urandom, 4'($urandom_range(0, 5)), 1'($urandom));
      for (int j = 0; j < 4; j++) send(1'b1, $urandom, $urandom, 4'($urandom_range(0, 5)), 1'($urandom));
    join
    wait_idle();

    // Backpressure for 5 cycles in RESP
    rsp_ready = 1'b0;
    send(1'b1, 32'h8000_00F0, 32'h0000_0FF0, SEL_XOR, 1'b1);
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();

    // Illegal sel
    send(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'hA, 1'b1);
    wait_idle();

    // Reset during EXEC, then a tie must go to requester 0
    send(1'b0, 32'hFFFF_0000, 32'h00FF_FF00, SEL_OR, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_ops_done", 64'(ops_done), 64'd0);
    fork
      send(1'b0, 32'h0000_0003, 32'h0000_0005, SEL_NOR, 1'b0);
      send(1'b1, 32'h0000_0003, 32'h0000_0005, SEL_NAND, 1'b1);
    join
    wait_idle();

    // 15 more ops, some illegal, for 17 since reset so the counter wraps
    for (int k = 0; k < 15; k++) begin
      send(1'($urandom), $urandom, $urandom, 4'($urandom_range(0, 7)), 1'($urandom));
      wait_idle();
    end
    @(negedge clk);
    chk("ops_done_wrap", 64'(ops_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=finish", total);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
